cdb_result_queue: RTL
=====================

# cdb_result_queue

Collects completed results from the execution functional units and serialises them onto the common data bus (CDB). Each unit raises a one-cycle `done` pulse and holds its result and tag stable until it is told the result was queued. This block is the consumer side of that handshake. It latches every `done`, arbitrates round-robin among waiting units, and writes one entry per cycle into a FIFO. It returns a one-cycle `queued` pulse to the accepted unit, and presents the FIFO head to reservation stations and the ROB as a valid/ready stream.

## Interface
- `NUM_FU`, 4: number of functional units served (≥2).
- `DATA_WIDTH`, 32: result width.
- `TAG_WIDTH`, 7: execution tag width.
- `DEPTH`, 8: FIFO entries, power of two.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fu_done`  in  NUM_FU  per-unit completion pulse; bit i belongs to unit i.
- `fu_result`  in  NUM_FU*DATA_WIDTH  unit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fu_tag`  in  NUM_FU*TAG_WIDTH  unit i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- `fu_queued`  out  NUM_FU  registered one-cycle pulse: unit i's result is now in the FIFO.
- `cdb_valid`  out  1  FIFO head valid.
- `cdb_tag`  out  TAG_WIDTH  head tag.
- `cdb_data`  out  DATA_WIDTH  head result.
- `cdb_ready`  in  1  consumer accepts head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.

## Operation
- Request vector: `req = fu_done | pending`. `pending[i]` is set when `fu_done[i]` is high and unit i is not granted that cycle. It is cleared when unit i is granted.
- Arbiter: round-robin over `req`, starting the search at `rr_ptr`. It produces at most one grant per cycle. On a grant to unit g, `rr_ptr <= (g+1) mod NUM_FU`. Without a grant, `rr_ptr` holds.
- Grant is allowed when `!full`, or when full and a pop occurs in the same cycle.
- Grant writes {`fu_tag[g]`, `fu_result[g]`} into the FIFO at the write pointer. Data is sampled directly from the unit inputs, which are stable while a request is outstanding.
- `fu_queued[g]` pulses high in the cycle after the grant. All other bits are 0.
- Pop: `cdb_valid && cdb_ready` advances the read pointer.
- `cdb_ready` while empty is ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy comes from `count`, incremented on push-only, decremented on pop-only, held on push+pop.
- `fu_done[i]` arriving while `pending[i]` is already set is a protocol violation. `pending[i]` simply stays set, and only one entry is ever written per outstanding request.
- Reset values: `pending=0`, `rr_ptr=0`, pointers=0, `count=0`, `fu_queued=0`, `cdb_valid=0`, `empty=1`, `full=0`.
- `cdb_tag`/`cdb_data` are don't-care while `cdb_valid=0`.
- Reset mid-operation discards all FIFO contents and pending requests. No `fu_queued` pulse follows the reset cycle.

## Timing
- `fu_done` in cycle t into an empty queue with no competition:
  - grant and write at the end of t;
  - `fu_queued` and `cdb_valid` high in cycle t+1.
- This is one-cycle latency, first-word-fall-through.
- Simultaneous completions are serialised, one per cycle. A unit waits at most NUM_FU−1 cycles behind others when the FIFO is not full.
- While full with `cdb_ready=0`, no grants occur, requests stay pending and no `fu_queued` is issued.
- In a full cycle with a pop, one grant still occurs and `count` stays DEPTH.
- `cdb_valid`, `count`, `full` and `empty` are registered or derived solely from registers. There is no combinational path from `fu_done` or `cdb_ready` to them.

## Structure
- The shared package holds:
  - the CDB entry struct {tag, data};
  - the default `DATA_WIDTH`/`TAG_WIDTH` constants, so functional units and reservation stations agree.
- Sub-module `cdb_fifo`: synchronous FIFO (push/pop/full/empty/count, FWFT head).
- The round-robin arbiter and pending logic stay inline.

## Test plan
- Unit 2 `done`, result 0xDEADBEEF, tag 0x15, empty queue → cycle t+1:
  - `fu_queued=4'b0100`;
  - `cdb_valid=1` with tag 0x15 and data 0xDEADBEEF;
  - pop with `cdb_ready=1` → `empty=1`.
- All four units `done` in the same cycle, `rr_ptr=0`, `cdb_ready=1` → `fu_queued` pulses for units 0, 1, 2, 3 in cycles t+1..t+4, and CDB tags appear in the same order.
- Fairness: unit 0 re-requests immediately after every grant while unit 3 is pending → unit 3 is granted within 4 cycles.
- Full stall:
  - `cdb_ready=0`, 8 entries queued, unit 1 `done` → no `fu_queued[1]`, `full=1`;
  - raise `cdb_ready` for one cycle → unit 1 is written that cycle, `fu_queued[1]` pulses next cycle, `count` stays 8.
- Wrap-around: 20 sequential single-unit results with `cdb_ready` toggling 1/0 → CDB order and data match the issue order exactly.
- Reset mid-operation: 5 entries queued and 2 pending, assert `rst` → next cycle `count=0`, `cdb_valid=0`, `fu_queued=0`, and no stale entry after release.

Source files
------------

// File: rtl/cdb_result_queue_pkg.sv
// Shared CDB definitions: entry layout and default widths used by producers and consumers.
package cdb_result_queue_pkg;

    localparam int unsigned CdbDataWidth = 32;
    localparam int unsigned CdbTagWidth  = 7;

    typedef struct packed {
        logic [CdbTagWidth-1:0]  tag;
        logic [CdbDataWidth-1:0] data;
    } cdb_entry_t;

    // Modular successor used by the round-robin search.
    function automatic int unsigned rr_index(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module cdb_fifo #(
    parameter int unsigned Width = 39,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign valid_o = !empty_o;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only alongside a pop; the freed slot is the write slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cdb_result_queue.sv
// Latches functional-unit completions, arbitrates round-robin and serialises them onto the CDB.
module cdb_result_queue
    import cdb_result_queue_pkg::*;
#(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned DATA_WIDTH = CdbDataWidth,
    parameter int unsigned TAG_WIDTH  = CdbTagWidth,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_done_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result_i,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag_i,
    output logic [NUM_FU-1:0]            fu_queued_o,
    output logic                         cdb_valid_o,
    output logic [TAG_WIDTH-1:0]         cdb_tag_o,
    output logic [DATA_WIDTH-1:0]        cdb_data_o,
    input  logic                         cdb_ready_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned RrW    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned EntryW = TAG_WIDTH + DATA_WIDTH;

    logic [NUM_FU-1:0] pending_q, pending_d;
    logic [NUM_FU-1:0] fu_queued_q, fu_queued_d;
    logic [RrW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_FU-1:0] req, gnt_oh;
    logic [RrW-1:0]    gnt_idx;
    logic              gnt_found, grant, pop;
    logic [EntryW-1:0] push_data, head_data;

    assign req = fu_done_i | pending_q;
    assign pop = cdb_valid_o && cdb_ready_i;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_found && req[rr_index(32'(rr_ptr_q), 32'(k), NUM_FU)]) begin
                gnt_found = 1'b1;
                gnt_idx   = RrW'(rr_index(32'(rr_ptr_q), 32'(k), NUM_FU));
            end
        end
    end

    // A full queue can still take an entry in the cycle its head is consumed.
    assign grant = gnt_found && (!full_o || pop);

    always_comb begin
        gnt_oh = '0;
        if (grant) gnt_oh[gnt_idx] = 1'b1;
        pending_d   = (pending_q | fu_done_i) & ~gnt_oh;
        fu_queued_d = gnt_oh;
        rr_ptr_d    = grant ? RrW'(rr_index(32'(gnt_idx), 32'd1, NUM_FU)) : rr_ptr_q;
    end

    assign push_data = {fu_tag_i[32'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH],
                        fu_result_i[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            fu_queued_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            fu_queued_q <= fu_queued_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    cdb_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (grant),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head_data),
        .valid_o (cdb_valid_o),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    assign cdb_tag_o   = head_data[EntryW-1:DATA_WIDTH];
    assign cdb_data_o  = head_data[DATA_WIDTH-1:0];
    assign fu_queued_o = fu_queued_q;

endmodule
